// File: rtl/aoi_vector_sequencer_pkg.sv
// Shared types, sizes and golden AOI function for the AOI vector sequencer.
package aoi_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } seq_state_e;

  localparam int unsigned NUM_VECS = 16;
  localparam int unsigned VEC_W    = 4;

  // Reference AOI: y = ~((a&b)|(c&d)) with {a,b,c,d} = vec[3:0].
  function automatic logic aoi_golden(input logic [VEC_W-1:0] vec);
    return ~((vec[3] & vec[2]) | (vec[1] & vec[0]));
  endfunction

endpackage

// File: rtl/aoi_vector_sequencer_if.sv
// Stimulus/response bundle between the sequencer and the AOI cell under test.
interface aoi_vector_sequencer_if #(
  parameter int unsigned ERR_W = 5
);
  logic             start;
  logic             y;
  logic             a;
  logic             b;
  logic             c;
  logic             d;
  logic             busy;
  logic             done;
  logic [ERR_W-1:0] err_cnt;
  logic             pass;
`ifdef AOI_SEQ_RESPMAP_EN
  logic [15:0]      resp_map;
`endif

  // Sequencer side.
  modport slave (
    input  start, y,
    output a, b, c, d, busy, done, err_cnt, pass
`ifdef AOI_SEQ_RESPMAP_EN
    , output resp_map
`endif
  );

  // Controller / cell side.
  modport master (
    output start, y,
    input  a, b, c, d, busy, done, err_cnt, pass
`ifdef AOI_SEQ_RESPMAP_EN
    , input resp_map
`endif
  );

endinterface

// File: rtl/aoi_golden_ref.sv
// Combinational golden AOI kept separate from the cell under test.
module aoi_golden_ref
  import aoi_seq_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic             y_c
);

  assign y_c = aoi_golden(vec);

endmodule

// File: rtl/aoi_vector_sequencer.sv
// Walks all 16 AOI input vectors, samples y after a settle time and scores it.
// Optional AOI_SEQ_RESPMAP_EN adds resp_map, the per-vector sampled y.
module aoi_vector_sequencer
  import aoi_seq_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned ERR_W       = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  aoi_vector_sequencer_if.slave  bus
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [VEC_W-1:0]  VEC_LAST  = VEC_W'(NUM_VECS - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

  seq_state_e        state_q, state_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [VEC_W-1:0]  abcd_q, abcd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              y_exp_c;
`ifdef AOI_SEQ_RESPMAP_EN
  logic [NUM_VECS-1:0] resp_q, resp_d;
`endif

  aoi_golden_ref u_golden (
    .vec (vec_q),
    .y_c (y_exp_c)
  );

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      hold_q  <= '0;
      err_q   <= '0;
      abcd_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef AOI_SEQ_RESPMAP_EN
      resp_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      abcd_q  <= abcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
`ifdef AOI_SEQ_RESPMAP_EN
      resp_q  <= resp_d;
`endif
    end
  end

  // Next-state logic; outputs are derived from the next state so they land with it.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    err_d   = err_q;
`ifdef AOI_SEQ_RESPMAP_EN
    resp_d  = resp_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = DRIVE;
          vec_d   = '0;
          hold_d  = '0;
          err_d   = '0;
`ifdef AOI_SEQ_RESPMAP_EN
          resp_d  = '0;
`endif
        end
      end
      DRIVE: begin
        if (hold_q == HOLD_LAST) begin
          state_d = SAMPLE;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      SAMPLE: begin
        if ((bus.y != y_exp_c) && (err_q != ERR_MAX)) begin
          err_d = err_q + ERR_W'(1);
        end
`ifdef AOI_SEQ_RESPMAP_EN
        resp_d[vec_q] = bus.y;
`endif
        if (vec_q == VEC_LAST) begin
          state_d = DONE;
        end else begin
          vec_d   = vec_q + VEC_W'(1);
          hold_d  = '0;
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == DRIVE) || (state_d == SAMPLE);
    done_d = (state_d == DONE);
    pass_d = done_d && (err_d == '0);
    abcd_d = busy_d ? vec_d : '0;
  end

  assign bus.a       = abcd_q[3];
  assign bus.b       = abcd_q[2];
  assign bus.c       = abcd_q[1];
  assign bus.d       = abcd_q[0];
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pass    = pass_q;
  assign bus.err_cnt = err_q;
`ifdef AOI_SEQ_RESPMAP_EN
  assign bus.resp_map = resp_q;
`endif

endmodule

// File: tb/tb_aoi_vector_sequencer.sv
// Scoreboard bench: two sequencers (ERR_W 5 and 3) share stimulus; y comes from a lookup-table cell.
module tb_aoi_vector_sequencer;

  localparam int unsigned HOLD    = 2;
  localparam int unsigned RUN_CYC = 16 * (HOLD + 1);

  typedef struct {
    int          n_err;
    logic [15:0] lut;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] lut = 16'h0000;
  logic [15:0] gmap;
  logic [3:0]  vec5, vec3;

  int n_chk  = 0;
  int n_pass = 0;

  exp_t q[$];
  exp_t e;
  int   bcnt = 0;
  bit   seq_bad = 1'b0;
  logic done_prev = 1'b0;

  always #5 clk = ~clk;

  aoi_vector_sequencer_if #(.ERR_W(5)) bus5 ();
  aoi_vector_sequencer_if #(.ERR_W(3)) bus3 ();

  assign vec5      = {bus5.a, bus5.b, bus5.c, bus5.d};
  assign vec3      = {bus3.a, bus3.b, bus3.c, bus3.d};
  assign bus5.start = start;
  assign bus3.start = start;
  assign bus5.y     = lut[vec5];
  assign bus3.y     = lut[vec3];

  aoi_vector_sequencer #(.HOLD_CYCLES(HOLD), .ERR_W(5)) dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus5.slave)
  );

  aoi_vector_sequencer #(.HOLD_CYCLES(HOLD), .ERR_W(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  // Truth table of the AOI built bit by bit from its boolean definition.
  function automatic logic [15:0] golden_map();
    logic [15:0] m;
    for (int i = 0; i < 16; i++) begin
      m[i] = !((((i / 8) % 2 == 1) && ((i / 4) % 2 == 1)) ||
               (((i / 2) % 2 == 1) && (i % 2 == 1)));
    end
    return m;
  endfunction

  function automatic int popcount(input logic [15:0] v);
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int sat(input int n, input int mx);
    return (n > mx) ? mx : n;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: counts busy cycles, checks the vector walk, scores each completed run.
  always @(negedge clk) begin
    if (!rst_n) begin
      bcnt = 0;
      seq_bad = 1'b0;
      done_prev = 1'b0;
    end else begin
      if (bus5.done && !done_prev) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("busy_cycles", bcnt, RUN_CYC);
          chk("vec_seq", int'(seq_bad), 0);
          chk("err5", bus5.err_cnt, sat(e.n_err, 31));
          chk("err3", bus3.err_cnt, sat(e.n_err, 7));
          chk("pass5", bus5.pass, (e.n_err == 0) ? 1 : 0);
          chk("pass3", bus3.pass, (e.n_err == 0) ? 1 : 0);
          chk("abcd_done", vec5, 0);
`ifdef AOI_SEQ_RESPMAP_EN
          chk("resp_map", bus5.resp_map, e.lut);
`endif
        end
        bcnt = 0;
        seq_bad = 1'b0;
      end else if (!bus5.busy) begin
        bcnt = 0;
        seq_bad = 1'b0;
      end
      if (bus5.busy) begin
        if (vec5 != 4'((bcnt / (HOLD + 1)) % 16) || vec3 != vec5 || bus5.done || !bus3.busy)
          seq_bad = 1'b1;
        bcnt++;
      end
      done_prev = bus5.done;
    end
  end

  task automatic wait_done(input bit noise, input bit hold_start);
    bit got = 1'b0;
    for (int i = 0; i < int'(RUN_CYC) + 20; i++) begin
      if (bus5.done) begin
        got = 1'b1;
        break;
      end
      start = hold_start ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
      @(negedge clk);
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  task automatic run_one(input logic [15:0] l, input bit noise);
    lut = l;
    q.push_back('{n_err: popcount(l ^ gmap), lut: l});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_latency", bus5.busy, 1);
    wait_done(noise, 1'b0);
    start = 1'b0;
    @(negedge clk);
    chk("done_level", bus5.done, 1);
    chk("err_held", bus5.err_cnt, sat(popcount(l ^ gmap), 31));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n5;
    gmap = golden_map();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus5.busy, 0);
    chk("rst_done", bus5.done, 0);
    chk("rst_pass", bus5.pass, 0);
    chk("rst_err", bus5.err_cnt, 0);
    chk("rst_abcd", vec5, 0);
`ifdef AOI_SEQ_RESPMAP_EN
    chk("rst_resp", bus5.resp_map, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", bus5.busy, 0);

    // Directed cells: correct, stuck-0, stuck-1, inverted.
    run_one(gmap, 1'b0);
    run_one(16'h0000, 1'b0);
    run_one(16'hFFFF, 1'b0);
    run_one(~gmap, 1'b0);
    // Random faulty cells with start toggled while busy.
    for (int r = 0; r < 6; r++) run_one(16'($urandom), 1'b1);

    // Abort mid-run at vec 5 in DRIVE.
    lut = 16'h0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus5.busy && vec5 == 4'd5) break;
      @(negedge clk);
    end
    n5 = 0;
    for (int v = 0; v < 5; v++) n5 += (gmap[v] != lut[v]) ? 1 : 0;
    chk("abort_vec", vec5, 5);
    chk("abort_err_pre", bus5.err_cnt, n5);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_abcd", vec5, 0);
    chk("abort_busy", bus5.busy, 0);
    chk("abort_err", bus5.err_cnt, 0);
    chk("abort_done", bus5.done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_one(gmap, 1'b0);

    // start held high: no restart while busy, immediate restart from DONE.
    lut = 16'h0000;
    q.push_back('{n_err: popcount(lut ^ gmap), lut: lut});
    start = 1'b1;
    @(negedge clk);
    wait_done(1'b0, 1'b1);
    q.push_back('{n_err: popcount(lut ^ gmap), lut: lut});
    @(negedge clk);
    chk("restart_busy", bus5.busy, 1);
    chk("restart_err", bus5.err_cnt, 0);
    chk("restart_done", bus5.done, 0);
    start = 1'b0;
    wait_done(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("final_done", bus5.done, 1);
    chk("queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
